// File: rtl/sipo_pkg.sv
// -----------------------------------------------------------------------------
// sipo_pkg
// Shared constants for the serial-in/parallel-out deserializer.
//   MODE_LSB_FIRST / MODE_MSB_FIRST : encodings of the per-word bit order
//   WIDTH_MIN / WIDTH_MAX           : legal word-width range, checked at
//                                     elaboration by sipo_deser
// -----------------------------------------------------------------------------
package sipo_pkg;

   localparam logic MODE_LSB_FIRST = 1'b0;
   localparam logic MODE_MSB_FIRST = 1'b1;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

endpackage : sipo_pkg

// File: rtl/sipo_shift_core.sv
// -----------------------------------------------------------------------------
// sipo_shift_core
// Bit-level half of the deserializer: shift register, bit counter and the
// per-word bit-order latch.
// Ports:
//   clk        in   clock, rising edge
//   clear      in   synchronous active-high reset
//   si         in   serial data bit
//   si_valid   in   bit strobe; all state holds when low
//   msb_first  in   live bit order, only looked at on the first bit of a word
//   word       out  WIDTH  shifted value including the bit now on si
//   word_done  out  high in the cycle whose edge samples the final bit
//   fill       out  CW     bits of the current partial word received (0..WIDTH-1)
// -----------------------------------------------------------------------------
module sipo_shift_core
   import sipo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             si,
   input  logic             si_valid,
   input  logic             msb_first,
   output logic [WIDTH-1:0] word,
   output logic             word_done,
   output logic [CW-1:0]    fill
);

   localparam logic [CW-1:0] FILL_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sh_q, sh_d;
   logic [CW-1:0]    fill_q, fill_d;
   logic             mode_q, mode_d;

   logic             mode_eff;
   logic [WIDTH-1:0] sh_shifted;
   logic             last_bit;

   always_comb begin
      // The first bit of a word takes the live order input; later bits use
      // the latched copy so mid-word changes cannot scramble the word.
      mode_eff   = (fill_q == '0) ? msb_first : mode_q;
      sh_shifted = (mode_eff == MODE_MSB_FIRST) ? {sh_q[WIDTH-2:0], si}
                                                : {si, sh_q[WIDTH-1:1]};
      last_bit   = (fill_q == FILL_LAST);

      sh_d   = sh_q;
      fill_d = fill_q;
      mode_d = mode_q;
      if (si_valid) begin
         sh_d   = sh_shifted;
         mode_d = mode_eff;
         fill_d = last_bit ? '0 : fill_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         sh_q   <= '0;
         fill_q <= '0;
         mode_q <= MODE_LSB_FIRST;
      end else begin
         sh_q   <= sh_d;
         fill_q <= fill_d;
         mode_q <= mode_d;
      end
   end

   // sh is not cleared on completion: every bit is overwritten by the next word.
   assign word      = sh_shifted;
   assign word_done = si_valid & last_bit;
   assign fill      = fill_q;

endmodule : sipo_shift_core

// File: rtl/sipo_deser.sv
// -----------------------------------------------------------------------------
// sipo_deser
// Serial-in/parallel-out deserializer with a one-word output buffer,
// valid/ready handshake and sticky overrun flag.
// Ports:
//   clk        in   clock, rising edge
//   clear      in   synchronous active-high reset, overrides all inputs
//   si         in   serial data bit
//   si_valid   in   si is sampled only when high
//   msb_first  in   1: first bit lands in po[WIDTH-1]; 0: first bit in po[0]
//   po         out  WIDTH  completed word, stable while po_valid & ~po_ready
//   po_valid   out  po holds an unconsumed word
//   po_ready   in   consumer takes po on an edge with po_valid & po_ready
//   fill       out  CW     bits of the current partial word received
//   overrun    out  sticky: a completed word was dropped
//   ovr_clr    in   clears overrun (a new drop on the same edge wins)
// -----------------------------------------------------------------------------
module sipo_deser
   import sipo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             si,
   input  logic             si_valid,
   input  logic             msb_first,
   output logic [WIDTH-1:0] po,
   output logic             po_valid,
   input  logic             po_ready,
   output logic [CW-1:0]    fill,
   output logic             overrun,
   input  logic             ovr_clr
);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("sipo_deser: WIDTH out of range");
   end

   logic [WIDTH-1:0] word;
   logic             word_done;

   sipo_shift_core #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_core (
      .clk       (clk),
      .clear     (clear),
      .si        (si),
      .si_valid  (si_valid),
      .msb_first (msb_first),
      .word      (word),
      .word_done (word_done),
      .fill      (fill)
   );

   logic [WIDTH-1:0] po_q, po_d;
   logic             po_valid_q, po_valid_d;
   logic             overrun_q, overrun_d;
   logic             slot_free;
   logic             drop;

   always_comb begin
      // Slot is usable if empty or being emptied on this very edge.
      slot_free  = ~po_valid_q | po_ready;
      drop       = word_done & ~slot_free;

      po_d       = po_q;
      po_valid_d = po_valid_q;
      overrun_d  = overrun_q;

      if (po_valid_q && po_ready) begin
         po_valid_d = 1'b0;
      end
      if (word_done && slot_free) begin
         po_d       = word;
         po_valid_d = 1'b1;
      end

      // Ordering makes a drop win over a simultaneous clear request.
      if (ovr_clr) begin
         overrun_d = 1'b0;
      end
      if (drop) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         po_q       <= '0;
         po_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         po_q       <= po_d;
         po_valid_q <= po_valid_d;
         overrun_q  <= overrun_d;
      end
   end

   assign po       = po_q;
   assign po_valid = po_valid_q;
   assign overrun  = overrun_q;

endmodule : sipo_deser

// File: tb/tb_sipo_deser.sv
// -----------------------------------------------------------------------------
// tb_sipo_deser
// Directed bench for sipo_deser: one instance at WIDTH=8 (a_*) and one at
// WIDTH=4 (b_*), driven one at a time from a single initial block.
// -----------------------------------------------------------------------------
module tb_sipo_deser;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // WIDTH=8 instance
   logic       a_clear, a_si, a_si_valid, a_msb_first, a_po_ready, a_ovr_clr;
   logic [7:0] a_po;
   logic       a_po_valid, a_overrun;
   logic [2:0] a_fill;

   // WIDTH=4 instance
   logic       b_clear, b_si, b_si_valid, b_msb_first, b_po_ready, b_ovr_clr;
   logic [3:0] b_po;
   logic       b_po_valid, b_overrun;
   logic [1:0] b_fill;

   sipo_deser #(.WIDTH(8)) dut_a (
      .clk       (clk),
      .clear     (a_clear),
      .si        (a_si),
      .si_valid  (a_si_valid),
      .msb_first (a_msb_first),
      .po        (a_po),
      .po_valid  (a_po_valid),
      .po_ready  (a_po_ready),
      .fill      (a_fill),
      .overrun   (a_overrun),
      .ovr_clr   (a_ovr_clr)
   );

   sipo_deser #(.WIDTH(4)) dut_b (
      .clk       (clk),
      .clear     (b_clear),
      .si        (b_si),
      .si_valid  (b_si_valid),
      .msb_first (b_msb_first),
      .po        (b_po),
      .po_valid  (b_po_valid),
      .po_ready  (b_po_ready),
      .fill      (b_fill),
      .overrun   (b_overrun),
      .ovr_clr   (b_ovr_clr)
   );

   int tests = 0;
   int fails = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Send one 8-bit word MSB-of-seq first in time. The order input flips to
   // ~msb from bit index 'toggle' onward (toggle<0: never); 'gap' idle cycles
   // follow each bit.
   task automatic send_a(input logic [7:0] seq, input logic msb, input int toggle, input int gap);
      for (int i = 0; i < 8; i++) begin
         a_si        = seq[7-i];
         a_si_valid  = 1'b1;
         a_msb_first = (toggle >= 0 && i >= toggle) ? ~msb : msb;
         tick();
         a_si_valid  = 1'b0;
         for (int g = 0; g < gap; g++) begin
            check($sformatf("a_fill_hold_%0d_%0d", i, g), 32'(a_fill), 32'((i + 1) % 8));
            tick();
         end
         if (i < 7) check($sformatf("a_fill_step_%0d", i), 32'(a_fill), 32'(i + 1));
      end
   endtask

   // Send one 4-bit word MSB-first in time; po_ready / ovr_clr are applied
   // only on the edge that samples the final bit.
   task automatic send_b(input logic [3:0] seq, input logic rdy_last, input logic clr_last);
      for (int i = 0; i < 4; i++) begin
         b_si        = seq[3-i];
         b_si_valid  = 1'b1;
         b_po_ready  = (i == 3) ? rdy_last : 1'b0;
         b_ovr_clr   = (i == 3) ? clr_last : 1'b0;
         tick();
      end
      b_si_valid = 1'b0;
      b_po_ready = 1'b0;
      b_ovr_clr  = 1'b0;
   endtask

   initial begin
      a_clear = 1'b1; a_si = 1'b0; a_si_valid = 1'b0; a_msb_first = 1'b1;
      a_po_ready = 1'b1; a_ovr_clr = 1'b0;
      b_clear = 1'b1; b_si = 1'b0; b_si_valid = 1'b0; b_msb_first = 1'b1;
      b_po_ready = 1'b0; b_ovr_clr = 1'b0;
      tick();
      check("rst_a_po", 32'(a_po), 32'h0);
      check("rst_a_po_valid", 32'(a_po_valid), 32'h0);
      check("rst_a_fill", 32'(a_fill), 32'h0);
      check("rst_a_overrun", 32'(a_overrun), 32'h0);
      check("rst_b_po_valid", 32'(b_po_valid), 32'h0);
      a_clear = 1'b0;
      b_clear = 1'b0;

      // MSB-first, back-to-back, ready high: C0 for exactly one cycle
      send_a(8'b1100_0000, 1'b1, -1, 0);
      check("msb_po", 32'(a_po), 32'hC0);
      check("msb_po_valid", 32'(a_po_valid), 32'h1);
      check("msb_fill_wrap", 32'(a_fill), 32'h0);
      tick();
      check("msb_one_cycle", 32'(a_po_valid), 32'h0);

      // LSB-first: first bit lands in po[0]
      send_a(8'b1100_0000, 1'b0, -1, 0);
      check("lsb_po", 32'(a_po), 32'h03);
      check("lsb_po_valid", 32'(a_po_valid), 32'h1);
      tick();

      // Flip msb_first after bit 3: word order is unaffected
      send_a(8'b1100_0000, 1'b0, 3, 0);
      check("toggle_po", 32'(a_po), 32'h03);
      tick();

      // Gapped strobes, one bit every 3 cycles
      send_a(8'b1100_0000, 1'b1, -1, 2);
      check("gap_po", 32'(a_po), 32'hC0);
      check("gap_po_valid", 32'(a_po_valid), 32'h0);
      a_po_ready = 1'b1;

      // po_ready held high while idle has no effect
      tick();
      check("idle_ready_valid", 32'(a_po_valid), 32'h0);

      // WIDTH=4 backpressure and overrun
      send_b(4'b1011, 1'b0, 1'b0);
      check("b_first_po", 32'(b_po), 32'hB);
      check("b_first_valid", 32'(b_po_valid), 32'h1);
      check("b_first_ovr", 32'(b_overrun), 32'h0);
      send_b(4'b0110, 1'b0, 1'b0);
      check("b_drop_po", 32'(b_po), 32'hB);
      check("b_drop_valid", 32'(b_po_valid), 32'h1);
      check("b_drop_ovr", 32'(b_overrun), 32'h1);
      b_ovr_clr = 1'b1;
      tick();
      b_ovr_clr = 1'b0;
      check("b_ovr_clr", 32'(b_overrun), 32'h0);
      send_b(4'b0001, 1'b0, 1'b1);
      check("b_set_wins", 32'(b_overrun), 32'h1);
      check("b_set_wins_po", 32'(b_po), 32'hB);
      b_ovr_clr = 1'b1;
      tick();
      b_ovr_clr = 1'b0;
      check("b_ovr_clr2", 32'(b_overrun), 32'h0);

      // Final bit on the same edge as draining the pending B: new word loads
      send_b(4'b0110, 1'b1, 1'b0);
      check("b_pass_po", 32'(b_po), 32'h6);
      check("b_pass_valid", 32'(b_po_valid), 32'h1);
      check("b_pass_ovr", 32'(b_overrun), 32'h0);
      b_po_ready = 1'b1;
      tick();
      b_po_ready = 1'b0;
      check("b_drain_valid", 32'(b_po_valid), 32'h0);
      check("b_drain_po_held", 32'(b_po), 32'h6);

      // clear mid-word with a buffered word and overrun pending
      a_po_ready = 1'b0;
      send_a(8'b1010_1010, 1'b1, -1, 0);
      check("clr_pre_po", 32'(a_po), 32'hAA);
      send_a(8'b1111_0000, 1'b1, -1, 0);
      check("clr_pre_ovr", 32'(a_overrun), 32'h1);
      for (int i = 0; i < 5; i++) begin
         a_si = 1'b1; a_si_valid = 1'b1;
         tick();
      end
      check("clr_pre_fill", 32'(a_fill), 32'h5);
      a_clear = 1'b1;
      a_po_ready = 1'b1;
      tick();
      a_clear = 1'b0;
      a_si_valid = 1'b0;
      check("clr_po", 32'(a_po), 32'h0);
      check("clr_po_valid", 32'(a_po_valid), 32'h0);
      check("clr_fill", 32'(a_fill), 32'h0);
      check("clr_overrun", 32'(a_overrun), 32'h0);
      send_a(8'h5A, 1'b1, -1, 0);
      check("fresh_po", 32'(a_po), 32'h5A);
      check("fresh_valid", 32'(a_po_valid), 32'h1);
      check("fresh_ovr", 32'(a_overrun), 32'h0);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_sipo_deser
